y_vector_streamer: RTL and testbench

- Output-side reader for the two-neuron datapath.
- Captures the 128-bit result vector Y (LANES signed Q6.10 words) on a valid/ready handshake.
- Streams Y out one 16-bit lane per beat on a valid/ready stream.
- Tracks the arg-max lane during streaming and reports it with a one-cycle done pulse.
- Sits between top's Y output and downstream consumers (host readback or classifier logic), mirroring how the X vector is packed on the input side.

---
 rtl/y_vector_streamer.sv | 112 +++++++++++
 tb/tb_y_vector_streamer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/y_vector_streamer.sv
// Output-side reader: captures the packed result vector Y, streams it one lane per beat,
// and reports the arg-max lane with a one-cycle done pulse once the last beat has gone out.
module y_vector_streamer #(
  parameter  int LANES = 8,
  parameter  int W     = 16,
  localparam int LW    = $clog2(LANES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [LANES*W-1:0]   y_in,
  input  logic                 y_valid,
  output logic                 y_ready,
  output logic signed [W-1:0]  out_data,
  output logic [LW-1:0]        out_lane,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [LW-1:0]        max_idx,
  output logic signed [W-1:0]  max_val,
  output logic                 done
);

  typedef enum logic [0:0] {IDLE, SEND} state_t;

  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  state_t                state_q, state_d;
  logic [LANES*W-1:0]    buf_p0;
  logic [LW-1:0]         lane_p0;
  logic [LW-1:0]         run_idx_p0;
  logic signed [W-1:0]   run_val_p0;
  logic                  cap, xfer, at_last;
  logic signed [W-1:0]   cur_word;
  logic [LW-1:0]         cand_idx;
  logic signed [W-1:0]   cand_val;

  // Lane 0 sits in the most-significant word of the packed vector.
  function automatic logic signed [W-1:0] lane_word(input logic [LANES*W-1:0] v,
                                                    input logic [LW-1:0] i);
    return v[(LANES - 1 - int'(i))*W +: W];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    y_ready   = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        y_ready = 1'b1;
        if (y_valid) state_d = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        if (out_ready && (lane_p0 == LAST_LANE)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cap      = y_ready & y_valid;
  assign xfer     = out_valid & out_ready;
  assign at_last  = (lane_p0 == LAST_LANE);
  assign cur_word = lane_word(buf_p0, lane_p0);
  assign out_data = cur_word;
  assign out_lane = lane_p0;
  assign out_last = out_valid & at_last;

  // Running arg-max including the beat currently on the bus; ties keep the lower lane.
  always_comb begin
    cand_idx = run_idx_p0;
    cand_val = run_val_p0;
    if (lane_p0 == '0 || cur_word > run_val_p0) begin
      cand_idx = lane_p0;
      cand_val = cur_word;
    end
  end

  // Stage 0: capture buffer, lane counter and running max; results publish with done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_p0     <= '0;
      lane_p0    <= '0;
      run_idx_p0 <= '0;
      run_val_p0 <= '0;
      max_idx    <= '0;
      max_val    <= '0;
      done       <= 1'b0;
    end else begin
      done <= xfer & at_last;
      if (cap) begin
        buf_p0  <= y_in;
        lane_p0 <= '0;
      end
      if (xfer) begin
        run_idx_p0 <= cand_idx;
        run_val_p0 <= cand_val;
        if (at_last) begin
          max_idx <= cand_idx;
          max_val <= cand_val;
        end else begin
          lane_p0 <= lane_p0 + LW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_y_vector_streamer.sv
// Randomized self-checking bench for y_vector_streamer against a per-vector reference model.
module tb_y_vector_streamer;

  localparam int LANES = 8;
  localparam int W     = 16;
  localparam int LW    = $clog2(LANES);

  typedef logic [W-1:0] vec_t [LANES];

  logic                clk = 1'b0;
  logic                reset;
  logic [LANES*W-1:0]  y_in;
  logic                y_valid;
  logic                y_ready;
  logic signed [W-1:0] out_data;
  logic [LW-1:0]       out_lane;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic [LW-1:0]       max_idx;
  logic signed [W-1:0] max_val;
  logic                done;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_max_idx = 0;
  logic [W-1:0] exp_max_val = '0;

  y_vector_streamer #(.LANES(LANES), .W(W)) dut (
    .clk(clk), .reset(reset), .y_in(y_in), .y_valid(y_valid), .y_ready(y_ready),
    .out_data(out_data), .out_lane(out_lane), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .max_idx(max_idx), .max_val(max_val), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [LANES*W-1:0] pack(input vec_t v);
    logic [LANES*W-1:0] p = '0;
    for (int i = 0; i < LANES; i++) p = (p << W) | (LANES*W)'(v[i]);
    return p;
  endfunction

  function automatic int ref_argmax(input vec_t v);
    int best = 0;
    for (int i = 1; i < LANES; i++)
      if ($signed(v[i]) > $signed(v[best])) best = i;
    return best;
  endfunction

  function automatic vec_t rand_vec(input int narrow);
    vec_t v;
    for (int i = 0; i < LANES; i++)
      v[i] = narrow ? W'($urandom_range(0, 3)) - W'(2) : W'($urandom);
    return v;
  endfunction

  // Called at a negedge while idle; returns at the negedge where lane 0 is visible.
  task automatic capture(input vec_t v);
    check("y_ready_idle", 32'(y_ready), 32'd1);
    y_in    = pack(v);
    y_valid = 1'b1;
    @(negedge clk);
    y_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: random ready, 2: pattern 1,0,0.
  // hold: keep y_valid high with nxt during streaming so nxt is captured on the done cycle.
  task automatic stream(input vec_t v, input int mode, input bit hold, input vec_t nxt);
    int k = 0;
    int cyc = 0;
    int a = ref_argmax(v);
    if (hold) begin
      y_in    = pack(nxt);
      y_valid = 1'b1;
    end
    while (k < LANES && cyc < 200) begin
      check("out_valid", 32'(out_valid), 32'd1);
      check("out_data",  32'($unsigned(out_data)), 32'(v[k]));
      check("out_lane",  32'(out_lane), 32'(k));
      check("out_last",  32'(out_last), 32'(k == LANES-1));
      check("y_ready_busy", 32'(y_ready), 32'd0);
      check("done_busy", 32'(done), 32'd0);
      check("max_idx_hold", 32'(max_idx), 32'(exp_max_idx));
      check("max_val_hold", 32'($unsigned(max_val)), 32'(exp_max_val));
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (cyc % 3 == 0);
      endcase
      if (out_ready) k++;
      @(negedge clk);
      cyc++;
    end
    check("beats_within_budget", 32'(k), 32'(LANES));
    out_ready   = 1'b1;
    exp_max_idx = a;
    exp_max_val = v[a];
    check("done_pulse", 32'(done), 32'd1);
    check("out_valid_done", 32'(out_valid), 32'd0);
    check("out_last_done", 32'(out_last), 32'd0);
    check("y_ready_done", 32'(y_ready), 32'd1);
    check("max_idx", 32'(max_idx), 32'(exp_max_idx));
    check("max_val", 32'($unsigned(max_val)), 32'(exp_max_val));
    @(negedge clk);
    if (hold) y_valid = 1'b0;
    else      check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    vec_t va, vb, vz;
    bit saw_done;
    reset = 1'b1; y_in = '0; y_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < LANES; i++) vz[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out_data", 32'($unsigned(out_data)), 32'd0);
    check("rst_max_idx", 32'(max_idx), 32'd0);
    check("rst_max_val", 32'($unsigned(max_val)), 32'd0);
    reset = 1'b0;
    #1 check("rst_y_ready", 32'(y_ready), 32'd1);
    @(negedge clk);

    for (int i = 0; i < LANES; i++) va[i] = 16'h0400;
    capture(va); stream(va, 0, 0, vz);

    va[1] = 16'h0000;
    capture(va); stream(va, 0, 0, vz);

    va = rand_vec(0);
    capture(va); stream(va, 2, 0, vz);

    va = '{16'hFC00, 16'h8000, 16'hFF00, 16'hFFFF, 16'hF000, 16'h0001, 16'hFE00, 16'h0001};
    capture(va); stream(va, 0, 0, vz);

    va = rand_vec(0); vb = rand_vec(0);
    capture(va); stream(va, 1, 1, vb); stream(vb, 0, 0, vz);

    for (int f = 0; f < 10; f++) begin
      va = rand_vec(f % 2);
      capture(va); stream(va, 1, 0, vz);
    end

    va = '{16'h0100, 16'h7FFF, 16'h0200, 16'h0300, 16'h0, 16'h0, 16'h0, 16'h0};
    capture(va); stream(va, 0, 0, vz);
    capture(rand_vec(0));
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_abort_lane", 32'(out_lane), 32'd3);
    reset = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_max_idx", 32'(max_idx), 32'd0);
    check("abort_max_val", 32'($unsigned(max_val)), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("abort_y_ready", 32'(y_ready), 32'd1);
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done || out_valid) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    exp_max_idx = 0; exp_max_val = '0;

    va = rand_vec(1);
    capture(va); stream(va, 1, 0, vz);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1);
  end

endmodule
